// File: rtl/key_debounce.sv
// Eight-way push-button conditioner: 2-flop synchroniser plus per-key stability
// counter, producing debounced active-low levels and one-cycle press/release pulses.
module key_debounce #(
   parameter int unsigned N_KEYS          = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [N_KEYS-1:0] raw_key,
   output logic [N_KEYS-1:0] user_key,
   output logic [N_KEYS-1:0] press_pulse,
   output logic [N_KEYS-1:0] release_pulse,
   output logic              key_event
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_KEYS-1:0]            s1_q, s2_q;
   logic [N_KEYS-1:0]            stb_q, stb_d;
   logic [N_KEYS-1:0]            press_q, press_d;
   logic [N_KEYS-1:0]            release_q, release_d;
   logic [N_KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      stb_d     = stb_q;
      cnt_d     = '0;
      press_d   = '0;
      release_d = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         // Any cycle of agreement leaves cnt_d at zero, restarting the count.
         if (s2_q[i] != stb_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               stb_d[i]     = s2_q[i];
               press_d[i]   = stb_q[i];
               release_d[i] = ~stb_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q      <= '1;
         s2_q      <= '1;
         stb_q     <= '1;
         cnt_q     <= '0;
         press_q   <= '0;
         release_q <= '0;
      end else begin
         s1_q      <= raw_key;
         s2_q      <= s1_q;
         stb_q     <= stb_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign user_key      = stb_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign key_event     = |{press_q, release_q};

endmodule
